// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: definitions shared by the instruction-memory loader files.
//   state_e        : loader FSM state encodings (CSUM is only entered when
//                    IMEM_LOADER_CHECKSUM_EN is defined)
//   BYTES_PER_WORD : host bytes packed into one instruction word
//   INST_W         : instruction word width
//   len_ok()       : accept check for a requested session length
package imem_loader_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int INST_W         = 32;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RECV  = 3'd1,
      WRITE = 3'd2,
      DONE  = 3'd3,
      CSUM  = 3'd4
   } state_e;

   // A session must write at least one word and must fit in the memory.
   function automatic logic len_ok(input int n, input int depth);
      return (n >= 1) && (n <= depth);
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: host byte stream, instruction-RAM write port and loader
// status in one bundle.
//   master : host side (drives start/num_words/byte_in/byte_valid)
//   slave  : loader side (drives byte_ready, mem_*, cpu_hold, busy, done, err)
interface imem_loader_if #(
   parameter int ADDR_W = 6
);
   import imem_loader_pkg::*;

   logic              start;
   logic [ADDR_W:0]   num_words;
   logic [7:0]        byte_in;
   logic              byte_valid;
   logic              byte_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [INST_W-1:0] mem_wdata;
   logic              cpu_hold;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output start, num_words, byte_in, byte_valid,
      input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err
   );

   modport slave (
      input  start, num_words, byte_in, byte_valid,
      output byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err
   );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// imem_loader_byte_packer: big-endian byte-to-word shift register.
//   clk         : system clock
//   clr_i       : synchronous clear of word and byte counter
//   shift_en_i  : shift byte_i in (first byte of a word ends in [31:24])
//   byte_i      : byte to shift
//   word_o      : packed contents including a byte being shifted this cycle
//   word_full_o : this shift completes a word
module imem_loader_byte_packer
   import imem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              clr_i,
   input  logic              shift_en_i,
   input  logic [7:0]        byte_i,
   output logic [INST_W-1:0] word_o,
   output logic              word_full_o
);

   logic [INST_W-1:0] word_q;
   logic [1:0]        cnt_q;

   always_ff @(posedge clk) begin
      if (clr_i) begin
         word_q <= '0;
         cnt_q  <= '0;
      end else if (shift_en_i) begin
         word_q <= {word_q[INST_W-9:0], byte_i};
         cnt_q  <= cnt_q + 2'd1;   // wraps to 0 on the last byte of a word
      end
   end

   // Look-ahead view lets the FSM capture the full word on the same edge
   // that accepts its last byte, so the write lands one cycle later.
   assign word_o      = shift_en_i ? {word_q[INST_W-9:0], byte_i} : word_q;
   assign word_full_o = shift_en_i && (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// imem_loader: packs a host byte stream into 32-bit words and writes them
// into the instruction RAM, holding the CPU in reset during the session.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : imem_loader_if.slave (start/num_words, byte stream, RAM write port,
//         cpu_hold/busy/done/err status)
// Optional: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte after the payload; a mismatch sets err.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 6
)(
   input  logic         clk,
   input  logic         rst,
   imem_loader_if.slave bus
);

   localparam int DEPTH = 1 << ADDR_W;

   state_e            state_q;
   logic [ADDR_W-1:0] last_q;      // index of the final word of the session
   logic [ADDR_W-1:0] word_cnt_q;
   logic              byte_ready_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [INST_W-1:0] mem_wdata_q;
   logic              cpu_hold_q;
   logic              busy_q;
   logic              done_q;
   logic              err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        csum_q;
`endif

   logic              idle_like;
   logic              start_acc;
   logic              byte_acc;
   logic              pk_shift;
   logic              pk_clr;
   logic [INST_W-1:0] pk_word;
   logic              pk_full;

   assign idle_like = (state_q == IDLE) || (state_q == DONE);
   assign start_acc = bus.start && idle_like && len_ok(int'(bus.num_words), DEPTH);
   assign byte_acc  = bus.byte_valid && byte_ready_q;
   assign pk_shift  = byte_acc && (state_q == RECV);
   // Clearing on reset is what discards a partial word from an aborted session.
   assign pk_clr    = rst || start_acc;

   imem_loader_byte_packer u_packer (
      .clk         (clk),
      .clr_i       (pk_clr),
      .shift_en_i  (pk_shift),
      .byte_i      (bus.byte_in),
      .word_o      (pk_word),
      .word_full_o (pk_full)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_q       <= '0;
         word_cnt_q   <= '0;
         byte_ready_q <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         cpu_hold_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q       <= '0;
`endif
      end else begin
         mem_we_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (bus.start) begin
                  if (start_acc) begin
                     last_q       <= ADDR_W'(bus.num_words - 1'b1);
                     word_cnt_q   <= '0;
                     done_q       <= 1'b0;
                     err_q        <= 1'b0;
                     busy_q       <= 1'b1;
                     cpu_hold_q   <= 1'b1;
                     byte_ready_q <= 1'b1;
                     state_q      <= RECV;
`ifdef IMEM_LOADER_CHECKSUM_EN
                     csum_q       <= '0;
`endif
                  end else begin
                     err_q   <= 1'b1;
                     done_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end
            end
            RECV: begin
               if (byte_acc) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum_q <= csum_q ^ bus.byte_in;
`endif
                  if (pk_full) begin
                     byte_ready_q <= 1'b0;
                     mem_we_q     <= 1'b1;
                     mem_addr_q   <= word_cnt_q;
                     mem_wdata_q  <= pk_word;
                     state_q      <= WRITE;
                  end
               end
            end
            WRITE: begin
               word_cnt_q <= word_cnt_q + 1'b1;
               if (word_cnt_q == last_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  byte_ready_q <= 1'b1;
                  state_q      <= CSUM;
`else
                  busy_q       <= 1'b0;
                  cpu_hold_q   <= 1'b0;
                  done_q       <= 1'b1;
                  state_q      <= DONE;
`endif
               end else begin
                  byte_ready_q <= 1'b1;
                  state_q      <= RECV;
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
               if (byte_acc) begin
                  if (bus.byte_in != csum_q) err_q <= 1'b1;
                  byte_ready_q <= 1'b0;
                  busy_q       <= 1'b0;
                  cpu_hold_q   <= 1'b0;
                  done_q       <= 1'b1;
                  state_q      <= DONE;
               end
            end
`endif
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.byte_ready = byte_ready_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.cpu_hold   = cpu_hold_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader. The host driver packs
// words into bytes and queues the expected RAM write (address, word, cycle)
// for every completed word; an independent monitor pops and compares on each
// mem_we. Build with IMEM_LOADER_CHECKSUM_EN to exercise the checksum byte.
`timescale 1ns/1ps
module tb_imem_loader;
   import imem_loader_pkg::*;

   localparam int ADDR_W = 6;
   localparam int DEPTH  = 1 << ADDR_W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

   imem_loader #(.ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int          addr;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] words_q[$];
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   // Monitor: every write must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL spurious_write: got addr=%0d data=%h required no write",
                        bus.mem_addr, bus.mem_wdata);
            end else begin
               e = exp_q.pop_front();
               $display("write addr=%0d data=%h cycle=%0d", bus.mem_addr, bus.mem_wdata, cyc);
               check("write_addr", 32'(bus.mem_addr), e.addr);
               check("write_data", bus.mem_wdata, e.data);
               check("write_latency", cyc, e.cyc);
            end
         end
      end
   end

   // All driver tasks start and end at posedge + 1.
   task automatic pulse_start(input int n);
      bus.start     = 1'b1;
      bus.num_words = (ADDR_W+1)'(n);
      @(posedge clk); #1;
      bus.start     = 1'b0;
   endtask

   // Offers one byte after 'gap' idle cycles; acc_cyc is the edge count at
   // which the transfer happens (the edge after a negedge seeing ready).
   task automatic send_byte(input logic [7:0] b, input int gap, output int acc_cyc);
      repeat (gap) begin @(posedge clk); #1; end
      bus.byte_valid = 1'b1;
      bus.byte_in    = b;
      acc_cyc        = -1;
      for (int w = 0; w < 200; w++) begin
         @(negedge clk);
         if (bus.byte_ready === 1'b1) begin
            acc_cyc = cyc + 1;
            break;
         end
         @(posedge clk); #1;
      end
      if (acc_cyc < 0) begin
         total++;
         bad++;
         $display("FAIL byte_timeout: byte_ready got 0 for 200 cycles, required 1");
      end
      @(posedge clk); #1;
      bus.byte_valid = 1'b0;
      bus.byte_in    = 8'($urandom);
   endtask

   // Loads words_q as one session; csum_flip != 0 corrupts the checksum byte.
   task automatic run_session(input int gap_lo, input int gap_hi, input bit mid_start,
                              input logic [7:0] csum_flip);
      int          n;
      int          acc;
      logic [7:0]  b;
      logic [7:0]  x;
      logic [31:0] w;
      logic        exp_err;
      n = words_q.size();
      x = 8'h00;
      $display("session words=%0d gap=%0d..%0d mid_start=%0d csum_flip=%h",
               n, gap_lo, gap_hi, mid_start, csum_flip);
      pulse_start(n);
      @(negedge clk);
      check("start_busy", bus.busy, 1);
      check("start_hold", bus.cpu_hold, 1);
      check("start_ready", bus.byte_ready, 1);
      check("start_done_clr", bus.done, 0);
      check("start_err_clr", bus.err, 0);
      @(posedge clk); #1;
      for (int i = 0; i < n; i++) begin
         w = words_q[i];
         for (int k = 0; k < BYTES_PER_WORD; k++) begin
            b = w[31-8*k -: 8];
            x = x ^ b;
            send_byte(b, $urandom_range(gap_hi, gap_lo), acc);
            if (k == BYTES_PER_WORD - 1) exp_q.push_back('{i, w, acc});
            if (mid_start && i == 0 && k == 1) pulse_start(1);
         end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      exp_err = (csum_flip != 8'h00);
      send_byte(x ^ csum_flip, $urandom_range(gap_hi, gap_lo), acc);
`else
      exp_err = 1'b0;
      @(negedge clk);
      check("write_cycle_hold", bus.cpu_hold, 1);
      @(posedge clk); #1;
`endif
      @(negedge clk);
      check("end_done", bus.done, 1);
      check("end_err", bus.err, exp_err);
      check("end_busy", bus.busy, 0);
      check("end_hold", bus.cpu_hold, 0);
      check("end_ready", bus.byte_ready, 0);
      @(posedge clk); #1;
   endtask

   task automatic bad_len(input int n);
      $display("bad length start num_words=%0d", n);
      pulse_start(n);
      @(negedge clk);
      check("badlen_err", bus.err, 1);
      check("badlen_done", bus.done, 0);
      check("badlen_busy", bus.busy, 0);
      check("badlen_ready", bus.byte_ready, 0);
      check("badlen_hold", bus.cpu_hold, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      int acc;
      bus.start      = 1'b0;
      bus.num_words  = '0;
      bus.byte_in    = 8'h00;
      bus.byte_valid = 1'b0;
      rst            = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", bus.byte_ready, 0);
      check("rst_we", bus.mem_we, 0);
      check("rst_addr", 32'(bus.mem_addr), 0);
      check("rst_wdata", bus.mem_wdata, 0);
      check("rst_hold", bus.cpu_hold, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_err", bus.err, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Two-word session, back-to-back bytes.
      words_q = {32'h00220820, 32'h00432022};
      run_session(0, 0, 1'b0, 8'h00);

      // byte_valid toggling every other cycle.
      words_q = {32'h01020304};
      run_session(1, 1, 1'b0, 8'h00);

      // Rejected lengths.
      bad_len(0);
      bad_len(DEPTH + 1);

      // Reset part-way through word 0, then a clean one-word session.
      $display("reset mid-session");
      pulse_start(1);
      send_byte(8'h11, 0, acc);
      send_byte(8'h22, 0, acc);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_busy", bus.busy, 0);
      check("abort_hold", bus.cpu_hold, 0);
      check("abort_ready", bus.byte_ready, 0);
      @(posedge clk); #1;
      words_q = {32'hAABBCCDD};
      run_session(0, 0, 1'b0, 8'h00);

      // start pulsed while busy must not shorten the session.
      words_q = {32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C};
      run_session(0, 1, 1'b1, 8'h00);

`ifdef IMEM_LOADER_CHECKSUM_EN
      words_q = {32'h01020304};
      run_session(0, 0, 1'b0, 8'h00);
      run_session(0, 0, 1'b0, 8'h01);
`endif

      // Randomized sessions.
      for (int r = 0; r < 8; r++) begin
         words_q.delete();
         for (int i = 0; i < int'($urandom_range(6, 1)); i++) words_q.push_back($urandom);
         run_session(0, 2, (r == 3), (r % 2 == 1) ? 8'($urandom_range(255, 1)) : 8'h00);
      end

      // Full-depth session touches every address.
      words_q.delete();
      for (int i = 0; i < DEPTH; i++) words_q.push_back($urandom);
      run_session(0, 0, 1'b0, 8'h00);

      repeat (10) @(posedge clk);
      #1;
      check("pending_writes", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface: accepts a host byte stream and packs it into 32-bit instruction words.
- Writes each word into the dual-use instruction RAM that the single-cycle R-type CPU fetches from via PC/Inst_code.
- Holds the CPU in reset (cpu_hold) while a load session runs; releases it when the session ends.

Parameters:
- ADDR_W, 6, word-address width; memory depth = 2**ADDR_W words.
- BYTES_PER_WORD, 4, bytes packed per instruction word; fixed for the 32-bit ISA.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load session.
- num_words  input  ADDR_W+1  words to load; latched on an accepted start.
- byte_in  input  8  host data byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader can accept a byte; transfer happens when byte_valid && byte_ready.
- mem_we  output  1  instruction-RAM write enable, one-cycle pulse.
- mem_addr  output  ADDR_W  word address of the write.
- mem_wdata  output  32  instruction word.
- cpu_hold  output  1  high while loading; ORed into the CPU rst by the top level.
- busy  output  1  session in progress.
- done  output  1  sticky; last session completed; cleared by the next accepted start.
- err  output  1  sticky; bad length (or checksum, see option); cleared by the next accepted start.

Behaviour:
- Reset values: byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, busy=0, done=0, err=0; state=IDLE; byte_cnt=0; word_cnt=0.
- States and transitions: IDLE, RECV, WRITE, DONE (plus CSUM with the option).
- IDLE/DONE:
  - start=1 with 1 <= num_words <= 2**ADDR_W: latch num_words; clear done, err, word_cnt and byte_cnt; go to RECV.
  - start=1 with num_words=0 or num_words > 2**ADDR_W: err=1, done=0; go to IDLE; no write occurs.
- RECV:
  - byte_ready=1, busy=1, cpu_hold=1.
  - Each accepted byte shifts into the packer, big-endian: the first byte lands in [31:24].
  - byte_cnt counts 0..3. Accepting the 4th byte (cycle N) sets byte_cnt to 0 and moves to WRITE.
- WRITE (cycle N+1):
  - byte_ready=0; mem_we=1; mem_addr=word_cnt; mem_wdata=packed word.
  - word_cnt increments.
  - If the written word was number num_words-1, go to DONE (or CSUM); otherwise go to RECV.
  - Latency from the 4th byte accepted to mem_we is exactly 1 cycle. Maximum throughput is one word per 5 cycles.
- DONE: done=1, busy=0, cpu_hold=0, byte_ready=0; stays until the next start.
- Bytes arriving while byte_ready=0 are not consumed; the host must hold byte_valid.
- start asserted while busy is ignored.
- Wrap: word_cnt never exceeds num_words-1, so mem_addr cannot wrap.
- Reset mid-session: immediate return to IDLE; the partial word is discarded; no further mem_we; words already written stay in RAM.
- mem_addr and mem_wdata hold their last value outside WRITE.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Enabled:
  - After the last WRITE, go to CSUM. CSUM sets byte_ready=1, busy=1, cpu_hold=1 and accepts exactly one byte.
  - If that byte differs from the XOR of all payload bytes, set err=1.
  - Then go to DONE; done=1 regardless of the checksum result.
- Disabled: WRITE goes straight to DONE; no CSUM state; err reflects only the length check.

Decomposition:
- Shared header imem_loader_defs:
  - state encodings IDLE=0, RECV=1, WRITE=2, DONE=3, CSUM=4;
  - BYTES_PER_WORD=4;
  - INST_W=32.
- One sub-module, byte_packer:
  - 32-bit shift register plus a 2-bit byte counter;
  - inputs shift_en and clr;
  - outputs word and word_full.

Test Plan:
- num_words=2, bytes 00,22,08,20,00,43,20,22 -> mem_we at addr0 = 0x00220820, then addr1 = 0x00432022; done=1; cpu_hold falls one cycle after the second write.
- byte_valid toggled every other cycle, num_words=1, bytes 01,02,03,04 -> a single write of 0x01020304; mem_we exactly 1 cycle after the 4th accepted byte.
- start with num_words=0, then with num_words=65 (ADDR_W=6) -> err=1 each time; no mem_we; busy stays 0.
- rst asserted after 2 bytes of word 0, then a new start with num_words=1 and bytes AA,BB,CC,DD -> only 0xAABBCCDD written at addr0.
- start pulsed mid-session -> ignored; the session completes with the original num_words.
- With IMEM_LOADER_CHECKSUM_EN: bytes 01,02,03,04 then checksum 04 -> err=0; checksum 05 -> err=1; done=1 in both cases.
